// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Sends one word per Send/Sent four-phase handshake as a frame made of a
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. Every bit lasts BIT_CYCLES = CLK_FREQ/BAUD_RATE clocks.
// Ports:
//   clk      system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   Send     transmit request (level); Din is latched when the request is accepted
//   Din      word to send
//   Sent     frame complete; held high until Send is deasserted
//   Busy     high from acceptance until the frame ends
//   Sout     serial line, idle high, registered
module uart_tx_param #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 19_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] Din,
  output logic                 Sent,
  output logic                 Busy,
  output logic                 Sout
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  // Guarded so an illegal BIT_CYCLES still elaborates far enough to report
  localparam int unsigned CNT_W      = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  // Parameter legality checks at elaboration
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_chk_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYCLES < 2) begin : g_chk_baud
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;

  logic [2:0]           state,     state_nxt;
  logic [CNT_W-1:0]     cnt,       cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt,   bit_cnt_nxt;
  logic                 stop_cnt,  stop_cnt_nxt;
  logic [DATA_BITS-1:0] shift,     shift_nxt;
  logic                 par_bit,   par_bit_nxt;
  logic                 sout_nxt;
  logic                 sent_nxt;
  logic                 busy_nxt;
  logic                 baud_tick;

  // State and datapath registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      Sout     <= 1'b1;
      Sent     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_bit_nxt;
      Sout     <= sout_nxt;
      Sent     <= sent_nxt;
      Busy     <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shift_nxt    = shift;
    par_bit_nxt  = par_bit;
    sout_nxt     = Sout;
    sent_nxt     = Sent;
    busy_nxt     = Busy;
    baud_tick    = (cnt == CNT_W'(BIT_CYCLES - 1));

    // Baud counter runs only while a bit is on the line
    if (state != S_IDLE && state != S_ACK) begin
      cnt_nxt = baud_tick ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (Send) begin
          shift_nxt   = Din;
          par_bit_nxt = (PARITY == 1) ? ~^Din : ^Din;
          busy_nxt    = 1'b1;
          sout_nxt    = 1'b0;
          state_nxt   = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          sout_nxt    = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              sout_nxt  = par_bit;
              state_nxt = S_PAR;
            end else begin
              sout_nxt     = 1'b1;
              stop_cnt_nxt = 1'b0;
              state_nxt    = S_STOP;
            end
          end else begin
            sout_nxt    = shift[1];
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      S_PAR: begin
        if (baud_tick) begin
          sout_nxt     = 1'b1;
          stop_cnt_nxt = 1'b0;
          state_nxt    = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            sent_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_ACK;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end

      S_ACK: begin
        // Hold Sent until the requester drops Send; no retransmit while high
        if (!Send) begin
          sent_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        sout_nxt  = 1'b1;
        sent_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param.
// Four instances at BIT_CYCLES=10 cover 8/odd/1, 8/even/1, 8/none/1 and 7/odd/2.
// Expected line bits are queued when a request is driven and popped while the
// line is sampled on falling edges.
module tb_uart_tx_param;

  localparam int unsigned BC = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] send;
  logic [8:0] din [4];
  logic [3:0] sent;
  logic [3:0] busy;
  logic [3:0] sout;

  int n_cmp;
  int n_bad;
  logic exp_q [$];

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .Reset_n(rst_n), .Send(send[0]), .Din(din[0][7:0]),
    .Sent(sent[0]), .Busy(busy[0]), .Sout(sout[0]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .Reset_n(rst_n), .Send(send[1]), .Din(din[1][7:0]),
    .Sent(sent[1]), .Busy(busy[1]), .Sout(sout[1]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .Reset_n(rst_n), .Send(send[2]), .Din(din[2][7:0]),
    .Sent(sent[2]), .Busy(busy[2]), .Sout(sout[2]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .Reset_n(rst_n), .Send(send[3]), .Din(din[3][6:0]),
    .Sent(sent[3]), .Busy(busy[3]), .Sout(sout[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one request at the current falling edge and follow the whole frame
  task automatic run_frame(input int idx, input logic [8:0] word, input int nbits,
                           input int par, input int nstop);
    int   ones;
    int   nb;
    logic cur;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(word[i]);
      if (word[i]) ones++;
    end
    if (par == 1) exp_q.push_back((ones % 2) == 0);
    if (par == 2) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
    nb = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;

    din[idx]  = word;
    send[idx] = 1'b1;
    @(posedge clk);  // accepting edge
    cur = 1'b1;
    for (int c = 0; c < nb * int'(BC); c++) begin
      @(negedge clk);
      if (c == 15) din[idx] = ~word;  // late Din change must be ignored
      if (c % int'(BC) == 0) begin
        if (exp_q.size() == 0) begin
          check("queue_underrun", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
        end
        check($sformatf("bit%0d_first", c / int'(BC)), 32'(sout[idx]), 32'(cur));
      end
      if (c % int'(BC) == int'(BC) - 1) begin
        check($sformatf("bit%0d_last", c / int'(BC)), 32'(sout[idx]), 32'(cur));
      end
      if (c == 0) check("busy_on", 32'(busy[idx]), 32'd1);
    end
    check("sent_not_early", 32'(sent[idx]), 32'd0);
    @(negedge clk);
    check("sent_on_time", 32'(sent[idx]), 32'd1);
    check("busy_off", 32'(busy[idx]), 32'd0);
    check("line_idle_ack", 32'(sout[idx]), 32'd1);
  endtask

  // Keep Send high for 'hold' cycles, then drop it for exactly one cycle
  task automatic release_req(input int idx, input int hold);
    int errs;
    errs = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (sent[idx] !== 1'b1 || sout[idx] !== 1'b1 || busy[idx] !== 1'b0) errs++;
    end
    check("ack_hold_quiet", 32'(errs), 32'd0);
    send[idx] = 1'b0;
    @(negedge clk);
    check("sent_cleared", 32'(sent[idx]), 32'd0);
    check("busy_idle", 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    n_cmp = 0;
    n_bad = 0;
    send  = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_sout%0d", i), 32'(sout[i]), 32'd1);
      check($sformatf("rst_sent%0d", i), 32'(sent[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset in the middle of data bit 3 (0xA5 bit 3 is 0)
    din[0]  = 9'h0A5;
    send[0] = 1'b1;
    repeat (46) @(negedge clk);
    check("mid_busy", 32'(busy[0]), 32'd1);
    check("mid_sout", 32'(sout[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_sout", 32'(sout[0]), 32'd1);
    check("async_busy", 32'(busy[0]), 32'd0);
    check("async_sent", 32'(sent[0]), 32'd0);
    send[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_sout", 32'(sout[0]), 32'd1);
    check("post_rst_busy", 32'(busy[0]), 32'd0);

    // Parity variants and wider stop
    run_frame(0, 9'h0A5, 8, 1, 1);
    release_req(0, 3);
    run_frame(1, 9'h0A5, 8, 2, 1);
    release_req(1, 2);
    run_frame(2, 9'h0A5, 8, 0, 1);
    release_req(2, 2);
    run_frame(3, 9'h041, 7, 1, 2);
    release_req(3, 2);

    // Long hold: one frame only, then a 1-cycle low gap and an immediate frame
    run_frame(0, 9'h03C, 8, 1, 1);
    release_req(0, 500);
    run_frame(0, 9'h0C3, 8, 1, 1);
    release_req(0, 1);

    // A few random words on the even-parity and 7-bit channels
    for (int k = 0; k < 3; k++) begin
      w = 9'($urandom_range(0, 255));
      run_frame(1, w, 8, 2, 1);
      release_req(1, 1);
      w = 9'($urandom_range(0, 127));
      run_frame(3, w, 7, 1, 2);
      release_req(3, 1);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
